multi_byte_add_ctrl: RTL and testbench

//  Sequencer that reuses one 8-bit carry look-ahead adder to add NBYTES-wide

---
 rtl/multi_byte_add_ctrl_pkg.sv | 14 +
 rtl/multi_byte_add_ctrl_cla.sv | 43 ++++
 rtl/multi_byte_add_ctrl.sv | 131 +++++++++++++
 tb/tb_multi_byte_add_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_byte_add_ctrl_pkg.sv
// Shared definitions for the byte-serial adder sequencer.
//   state_t : 2-bit FSM encoding (ST_IDLE, ST_ADD, ST_DONE)
//   BYTE_W  : width of the shared adder slice
package multi_byte_add_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multi_byte_add_ctrl_cla.sv
// Carry_Look_Ahead_Adder_8bit: purely combinational 8-bit carry look-ahead adder.
// Ports:
//   a, b : 8-bit addends
//   c0   : carry-in
//   s    : 8-bit sum
//   c8   : carry-out of bit 7
module Carry_Look_Ahead_Adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c0,
  output logic [7:0] s,
  output logic       c8
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is built as a flat sum of products of generate/propagate
  // terms and c0, so no carry depends on a lower carry signal.
  always_comb begin
    logic acc;
    logic prop;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < 8; i++) begin
      acc  = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = acc | (prop & c0);
    end
  end

  assign s  = p ^ c[7:0];
  assign c8 = c[8];

endmodule

// File: rtl/multi_byte_add_ctrl.sv
// multi_byte_add_ctrl: adds NBYTES-wide operands one byte per cycle, LSB first,
// through a single shared 8-bit carry look-ahead adder. The carry is registered
// between bytes.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   start        : request, honoured only in IDLE or DONE
//   a, b, cin    : operands and carry-in, captured when start is accepted
//   sub          : (only with SUBTRACT_EN) 1 = compute a-b, cin ignored
//   busy         : high while bytes are being summed
//   done         : one-cycle pulse, sum/cout valid
//   sum, cout    : result, held until the next accepted start
// Configuration macro: SUBTRACT_EN adds the sub port and subtraction mode.
module multi_byte_add_ctrl
  import multi_byte_add_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
`ifdef SUBTRACT_EN
  input  logic                     sub,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout
);

  localparam int W    = BYTE_W * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t            state;
  state_t            next_state;
  logic [IDXW-1:0]   idx;
  logic              carry;
  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic              accept;
  logic              last_byte;
  logic              sub_mode;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] byte_sum;
  logic              byte_carry;

`ifdef SUBTRACT_EN
  assign sub_mode = sub;
`else
  assign sub_mode = 1'b0;
`endif

  assign last_byte = (idx == IDXW'(NBYTES - 1));
  assign a_byte    = a_r[BYTE_W*idx +: BYTE_W];
  assign b_byte    = b_r[BYTE_W*idx +: BYTE_W];

  Carry_Look_Ahead_Adder_8bit u_cla (
    .a  (a_byte),
    .b  (b_byte),
    .c0 (carry),
    .s  (byte_sum),
    .c8 (byte_carry)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and status decode. A start in DONE chains straight into the
  // next add, which is what gives one result per NBYTES+1 cycles.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = start;
        if (start) next_state = ST_ADD;
      end
      ST_ADD: begin
        busy = 1'b1;
        if (last_byte) next_state = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        accept = start;
        next_state = start ? ST_ADD : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Operand capture and byte-serial accumulation. Subtraction stores ~b and
  // seeds the carry with 1, giving a + ~b + 1 = a - b. idx saturates on the
  // last byte so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      a_r   <= a;
      b_r   <= sub_mode ? ~b : b;
      carry <= sub_mode ? 1'b1 : cin;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == ST_ADD) begin
      sum[BYTE_W*idx +: BYTE_W] <= byte_sum;
      carry <= byte_carry;
      if (last_byte) begin
        cout <= byte_carry;
      end else begin
        idx <= idx + IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_multi_byte_add_ctrl.sv
// Self-checking bench for multi_byte_add_ctrl with NBYTES=4. Expected results
// come from a plain 33-bit reference sum and are queued when a request is
// driven; a monitor pops and compares them whenever done pulses.
// Define SUBTRACT_EN to also exercise the subtraction mode.
module tb_multi_byte_add_ctrl;

  localparam int NB = 4;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    int          accept_cycle;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;

  exp_t        sb_q[$];
  int          check_count;
  int          error_count;
  int          cycle_count;
  int          busy_run;
  int          done_seen;
  int          pushed;
  logic [31:0] last_sum;
  logic        last_cout;

  multi_byte_add_ctrl #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SUBTRACT_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so latency can be measured in cycles.
  always @(posedge clk) cycle_count++;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one request, queue its reference result, and hold start for the
  // given number of edges (more than one when the DUT is still busy).
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                               input logic cv, input logic sv,
                               input int edges, input bit keep);
    exp_t        e;
    logic [31:0] bm;
    logic [32:0] full;
    a     = av;
    b     = bv;
    cin   = cv;
    sub   = sv;
    start = 1'b1;
    bm    = sv ? ~bv : bv;
    full  = {1'b0, av} + {1'b0, bm} + {32'd0, (sv ? 1'b1 : cv)};
    e.sum          = full[31:0];
    e.cout         = full[32];
    e.accept_cycle = cycle_count + edges;
    sb_q.push_back(e);
    pushed++;
    last_sum  = full[31:0];
    last_cout = full[32];
    repeat (edges) @(posedge clk);
    #1;
    if (!keep) start = 1'b0;
  endtask

  // Bounded wait for every queued result to come out.
  task automatic waitDrain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("drain", 64'(sb_q.size()), 64'd0);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (busy) busy_run++;
      if (done) begin
        if (sb_q.size() == 0) begin
          checkOutput("spurious_done", 64'(done), 64'd0);
        end else begin
          e = sb_q.pop_front();
          done_seen++;
          checkOutput("sum", 64'(sum), 64'(e.sum));
          checkOutput("cout", 64'(cout), 64'(e.cout));
          checkOutput("latency", 64'(cycle_count - e.accept_cycle), 64'(NB));
          checkOutput("busy_cycles", 64'(busy_run), 64'(NB));
        end
        busy_run = 0;
      end
    end
  end

  // Hard stop in case something wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", error_count);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    check_count = 0;
    error_count = 0;
    cycle_count = 0;
    busy_run    = 0;
    done_seen   = 0;
    pushed      = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_sum", 64'(sum), 64'd0);
    checkOutput("reset_cout", 64'(cout), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Simple add
    applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1, 0);
    waitDrain();

    // Carry ripples through every byte
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1, 0);
    waitDrain();

    // Result is held after done
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sum_held", 64'(sum), 64'(last_sum));
    checkOutput("cout_held", 64'(cout), 64'(last_cout));

    // Start during ADD is ignored
    applyStimulus(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1, 0);
    @(posedge clk);
    #1;
    a     = 32'hDEAD_BEEF;
    b     = 32'h1234_5678;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDrain();
    repeat (6) @(posedge clk);
    #1;

    // Back-to-back with start held high; second request waits in the DONE cycle
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1, 1);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, NB + 1, 0);
    waitDrain();

    // A few random operands
    for (int i = 0; i < 4; i++) begin
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1, 0);
      waitDrain();
    end

`ifdef SUBTRACT_EN
    applyStimulus(32'd5, 32'd7, 1'b0, 1'b1, 1, 0);
    waitDrain();
    applyStimulus(32'd7, 32'd5, 1'b1, 1'b1, 1, 0);
    waitDrain();
    applyStimulus(32'h1234_5678, 32'h0000_0001, 1'b1, 1'b0, 1, 0);
    waitDrain();
`endif

    // Reset in the middle of an add aborts it with no done pulse
    applyStimulus(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0, 1, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_sum", 64'(sum), 64'd0);
    checkOutput("midrst_cout", 64'(cout), 64'd0);
    sb_q.delete();
    pushed--;
    busy_run = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("post_rst_busy", 64'(busy), 64'd0);

    checkOutput("done_count", 64'(done_seen), 64'(pushed));

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
